// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int MDU_OP_WIDTH = 3;

  // RV32M operation encodings (funct3 order)
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_ITER_MUL = 2'd1,
    MDU_ITER_DIV = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: 33 cycles accept-to-resp_valid for normal ops, 1 cycle for div-by-zero/overflow.
// Backpressure: resp_valid/mdu_res hold while resp_ready is low; req_ready only high in IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               abandon the operation in flight (takes priority over handshakes)
//   req_valid/req_ready request channel; mdu_op, mdu_src1, mdu_src2 sampled at accept
//   resp_valid/resp_ready response channel; mdu_res registered result
//   busy                high whenever the unit is not IDLE
module mdu
  import mdu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op,
  input  logic [CPU_WIDTH-1:0]    mdu_src1,
  input  logic [CPU_WIDTH-1:0]    mdu_src2,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CPU_WIDTH-1:0]    mdu_res,
  output logic                    busy
);

  mdu_state_t              state;
  logic [63:0]             acc;     // shared product / {remainder, quotient} register
  logic [CPU_WIDTH-1:0]    opnd;    // multiplicand or divisor magnitude
  logic [5:0]              cnt;
  logic [MDU_OP_WIDTH-1:0] op_q;
  logic                    neg_q;   // sign to apply to the selected result

  // ---------------- operand conditioning at accept ----------------
  logic                 src1_signed, src2_signed;
  logic                 sign1, sign2, neg_in;
  logic [CPU_WIDTH-1:0] mag1, mag2;
  logic                 div_zero, div_ovf, special;
  logic [CPU_WIDTH-1:0] special_res;

  always_comb begin
    src1_signed = (mdu_op == MDU_MULH) || (mdu_op == MDU_MULHSU) ||
                  (mdu_op == MDU_DIV)  || (mdu_op == MDU_REM);
    src2_signed = (mdu_op == MDU_MULH) || (mdu_op == MDU_DIV) || (mdu_op == MDU_REM);
    sign1  = src1_signed & mdu_src1[CPU_WIDTH-1];
    sign2  = src2_signed & mdu_src2[CPU_WIDTH-1];
    mag1   = sign1 ? (~mdu_src1 + 32'd1) : mdu_src1;
    mag2   = sign2 ? (~mdu_src2 + 32'd1) : mdu_src2;
    // Remainder takes the dividend's sign; everything else takes sign1^sign2.
    neg_in = ((mdu_op == MDU_REM) || (mdu_op == MDU_REMU)) ? sign1 : (sign1 ^ sign2);

    div_zero = mdu_op[2] && (mdu_src2 == 32'd0);
    div_ovf  = ((mdu_op == MDU_DIV) || (mdu_op == MDU_REM)) &&
               (mdu_src1 == 32'h8000_0000) && (mdu_src2 == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    // op[1] distinguishes REM/REMU from DIV/DIVU within the divide group
    if (div_zero) special_res = mdu_op[1] ? mdu_src1 : 32'hFFFF_FFFF;
    else          special_res = mdu_op[1] ? 32'd0    : 32'h8000_0000;
  end

  // ---------------- one iteration step ----------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] iter_next;
  logic [63:0] prod_neg;
  logic [31:0] fix_res;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};

    // Divide: shift {rem, quot} left; the 33-bit window is the shifted partial remainder.
    // When it is >= divisor the difference always fits in 32 bits.
    div_rem  = acc[63:31];
    div_ge   = div_rem >= {1'b0, opnd};
    div_diff = div_rem[31:0] - opnd;
    div_next = {(div_ge ? div_diff : div_rem[31:0]), acc[30:0], div_ge};

    iter_next = (state == MDU_ITER_DIV) ? div_next : mul_next;
    prod_neg  = ~iter_next + 64'd1;

    case (op_q)
      MDU_MUL:                        fix_res = neg_q ? prod_neg[31:0]  : iter_next[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = neg_q ? prod_neg[63:32] : iter_next[63:32];
      MDU_DIV, MDU_DIVU:              fix_res = neg_q ? (~iter_next[31:0] + 32'd1)  : iter_next[31:0];
      default:                        fix_res = neg_q ? (~iter_next[63:32] + 32'd1) : iter_next[63:32];
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MDU_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      mdu_res    <= '0;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
    end else if (flush) begin
      state      <= MDU_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (req_valid) begin
            op_q      <= mdu_op;
            neg_q     <= neg_in;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (special) begin
              mdu_res    <= special_res;
              resp_valid <= 1'b1;
              state      <= MDU_DONE;
            end else if (mdu_op[2]) begin
              acc   <= {32'd0, mag1};
              opnd  <= mag2;
              state <= MDU_ITER_DIV;
            end else begin
              acc   <= {32'd0, mag2};
              opnd  <= mag1;
              state <= MDU_ITER_MUL;
            end
          end
        end
        MDU_ITER_MUL, MDU_ITER_DIV: begin
          acc <= iter_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            mdu_res    <= fix_res;
            resp_valid <= 1'b1;
            state      <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
